// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that steers one of NUM_REQ valid/ready producers through a shared
// N:1 mux into a single-entry output buffer, tagging each buffered word with its source.
module rr_mux_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       in_valid,
   input  logic [NUM_REQ*WIDTH-1:0] in_data,
   output logic [NUM_REQ-1:0]       in_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [SRC_W-1:0]         out_src,
   input  logic                     out_ready
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t             state;
   logic [SRC_W-1:0]   rr_ptr;
   logic               load;
   logic               grant_found;
   logic [SRC_W-1:0]   grant_idx;
   logic [SRC_W:0]     scan_sum;
   logic [SRC_W-1:0]   scan_idx;
   logic [WIDTH-1:0]   sel_data;

   // Pointer wrap compares against NUM_REQ-1 so non-power-of-two counts never alias.
   function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
      if (idx == SRC_W'(NUM_REQ - 1))
         return '0;
      else
         return idx + SRC_W'(1);
   endfunction

   assign out_valid = (state == FULL);
   assign load      = !out_valid || out_ready;

   // Scan requesters starting at rr_ptr; the first valid one wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_sum    = '0;
      scan_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
         if (scan_sum >= (SRC_W+1)'(NUM_REQ))
            scan_sum = scan_sum - (SRC_W+1)'(NUM_REQ);
         scan_idx = scan_sum[SRC_W-1:0];
         if (!grant_found && in_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Only the granted slice is selected, so X on other requesters cannot propagate.
   assign sel_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

   always_comb begin
      in_ready = '0;
      if (rst_n && load && grant_found)
         in_ready[grant_idx] = 1'b1;
   end

   // Output buffer stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= EMPTY;
         out_data <= '0;
         out_src  <= '0;
         rr_ptr   <= '0;
      end else if (load) begin
         if (grant_found) begin
            state    <= FULL;
            out_data <= sel_data;
            out_src  <= grant_idx;
            rr_ptr   <= wrap_inc(grant_idx);
         end else begin
            state    <= EMPTY;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed table-driven bench for rr_mux_arbiter (NUM_REQ=4, WIDTH=8) plus a few
// hand-written sequences for X isolation and grant invariants.
module tb_rr_mux_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int SRC_W   = 2;

   logic                     clk;
   logic                     rst_n;
   logic [NUM_REQ-1:0]       in_valid;
   logic [NUM_REQ*WIDTH-1:0] in_data;
   logic [NUM_REQ-1:0]       in_ready;
   logic                     out_valid;
   logic [WIDTH-1:0]         out_data;
   logic [SRC_W-1:0]         out_src;
   logic                     out_ready;

   int checks;
   int errors;

   rr_mux_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One row = one clock: inputs for the cycle, expected in_ready for the cycle,
   // and expected buffer contents held going into the cycle's rising edge.
   typedef struct {
      logic        rst_n;
      logic [3:0]  iv;
      logic [31:0] data;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        chk_out;
      logic        exp_v;
      logic [7:0]  exp_d;
      logic [1:0]  exp_s;
   } vec_t;

   localparam logic [31:0] D = 32'h4332_2110;
   localparam logic [31:0] A = 32'h43A5_2110;
   localparam int NVEC = 28;

   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic r, input logic [3:0] iv, input logic [31:0] d,
                               input logic ordy, input logic [3:0] rdy, input logic chk,
                               input logic ov, input logic [7:0] od, input logic [1:0] os);
      vec_t t;
      t.rst_n = r; t.iv = iv; t.data = d; t.ordy = ordy; t.exp_rdy = rdy;
      t.chk_out = chk; t.exp_v = ov; t.exp_d = od; t.exp_s = os;
      return t;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;

      //                 rst  iv     data ordy rdy    chk  ov    od     os
      vecs[0]  = mk(1'b0, 4'hF, D, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0);
      vecs[1]  = mk(1'b0, 4'hF, D, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00, 2'd0);
      vecs[2]  = mk(1'b1, 4'hF, D, 1'b1, 4'h1, 1'b1, 1'b0, 8'h00, 2'd0);
      vecs[3]  = mk(1'b1, 4'hF, D, 1'b1, 4'h2, 1'b1, 1'b1, 8'h10, 2'd0);
      vecs[4]  = mk(1'b1, 4'hF, D, 1'b1, 4'h4, 1'b1, 1'b1, 8'h21, 2'd1);
      vecs[5]  = mk(1'b1, 4'hF, D, 1'b1, 4'h8, 1'b1, 1'b1, 8'h32, 2'd2);
      vecs[6]  = mk(1'b1, 4'hF, D, 1'b1, 4'h1, 1'b1, 1'b1, 8'h43, 2'd3);
      vecs[7]  = mk(1'b1, 4'hF, D, 1'b1, 4'h2, 1'b1, 1'b1, 8'h10, 2'd0);
      vecs[8]  = mk(1'b1, 4'hF, D, 1'b0, 4'h0, 1'b1, 1'b1, 8'h21, 2'd1);
      vecs[9]  = mk(1'b1, 4'hF, D, 1'b0, 4'h0, 1'b1, 1'b1, 8'h21, 2'd1);
      vecs[10] = mk(1'b1, 4'hF, D, 1'b0, 4'h0, 1'b1, 1'b1, 8'h21, 2'd1);
      vecs[11] = mk(1'b1, 4'hF, D, 1'b1, 4'h4, 1'b1, 1'b1, 8'h21, 2'd1);
      vecs[12] = mk(1'b1, 4'h3, D, 1'b1, 4'h1, 1'b1, 1'b1, 8'h32, 2'd2);
      vecs[13] = mk(1'b1, 4'h3, D, 1'b1, 4'h2, 1'b1, 1'b1, 8'h10, 2'd0);
      vecs[14] = mk(1'b1, 4'h8, D, 1'b1, 4'h8, 1'b1, 1'b1, 8'h21, 2'd1);
      vecs[15] = mk(1'b1, 4'h0, D, 1'b1, 4'h0, 1'b1, 1'b1, 8'h43, 2'd3);
      vecs[16] = mk(1'b1, 4'h0, D, 1'b0, 4'h0, 1'b1, 1'b0, 8'h43, 2'd3);
      vecs[17] = mk(1'b1, 4'h4, A, 1'b1, 4'h4, 1'b1, 1'b0, 8'h43, 2'd3);
      vecs[18] = mk(1'b1, 4'h0, A, 1'b0, 4'h0, 1'b1, 1'b1, 8'hA5, 2'd2);
      vecs[19] = mk(1'b1, 4'hA, A, 1'b0, 4'h0, 1'b1, 1'b1, 8'hA5, 2'd2);
      vecs[20] = mk(1'b1, 4'h8, D, 1'b1, 4'h8, 1'b1, 1'b1, 8'hA5, 2'd2);
      vecs[21] = mk(1'b0, 4'hA, D, 1'b0, 4'h0, 1'b1, 1'b1, 8'h43, 2'd3);
      vecs[22] = mk(1'b1, 4'hA, D, 1'b0, 4'h2, 1'b1, 1'b0, 8'h00, 2'd0);
      vecs[23] = mk(1'b0, 4'hF, D, 1'b0, 4'h0, 1'b1, 1'b1, 8'h21, 2'd1);
      vecs[24] = mk(1'b1, 4'hA, D, 1'b1, 4'h2, 1'b1, 1'b0, 8'h00, 2'd0);
      vecs[25] = mk(1'b1, 4'hA, D, 1'b1, 4'h8, 1'b1, 1'b1, 8'h21, 2'd1);
      vecs[26] = mk(1'b1, 4'h0, D, 1'b1, 4'h0, 1'b1, 1'b1, 8'h43, 2'd3);
      vecs[27] = mk(1'b1, 4'h0, D, 1'b1, 4'h0, 1'b1, 1'b0, 8'h43, 2'd3);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         rst_n     = vecs[i].rst_n;
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].data;
         out_ready = vecs[i].ordy;
         #1;
         check("in_ready", i, 32'(in_ready), 32'(vecs[i].exp_rdy));
         if (vecs[i].chk_out) begin
            check("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_v));
            check("out_data",  i, 32'(out_data),  32'(vecs[i].exp_d));
            check("out_src",   i, 32'(out_src),   32'(vecs[i].exp_s));
         end
      end

      // Buffer is EMPTY, rr_ptr=0: non-granted slices carry X, only slice 2 is valid.
      @(negedge clk);
      in_valid  = 4'b0100;
      in_data   = {8'hxx, 8'h5A, 8'hxx, 8'hxx};
      out_ready = 1'b1;
      #1;
      check("x_iso_ready", 0, 32'(in_ready), 32'h4);
      @(negedge clk);
      in_valid = 4'b0000;
      in_data  = D;
      #1;
      check("x_iso_valid", 0, 32'(out_valid), 32'h1);
      check("x_iso_data",  0, 32'(out_data),  32'h5A);
      check("x_iso_src",   0, 32'(out_src),   32'h2);

      // Random traffic: grant must be at most one-hot and only to a valid requester.
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         in_valid  = 4'($urandom_range(0, 15));
         out_ready = 1'($urandom_range(0, 1));
         #1;
         check("onehot0", n, 32'($countones(in_ready) <= 1), 32'h1);
         check("grant_subset", n, 32'(in_ready & ~in_valid), 32'h0);
         check("grant_present", n, 32'(|in_ready),
               32'((!out_valid || out_ready) && (|in_valid)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
